cc_deserializer: RTL and testbench

Wrap-burst line assembler for the cache controller's memory read path. It accepts a critical-word-first start offset, collects eight 64-bit beats from the memory read-data channel, and places each beat at its wrapped word position. It then writes one 518-bit entry, {offset, 512-bit line}, into the line FIFO that feeds the cache fill logic and the CPU-side serializer.

---
 rtl/cc_deserializer.sv | 119 +++++++++++
 tb/tb_cc_deserializer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_deserializer.sv
// Wrap-burst line assembler: gathers eight 64-bit beats critical-word-first
// into a 512-bit line and pushes {offset, line} into the line FIFO.
module cc_deserializer (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_valid_i,
    input  logic [5:0]   start_offset_i,
    output logic         start_ready_o,
    input  logic [63:0]  mem_rdata_i,
    input  logic         mem_rlast_i,
    input  logic         mem_rvalid_i,
    output logic         mem_rready_o,
    input  logic         fifo_full_i,
    output logic         fifo_wren_o,
    output logic [517:0] fifo_wdata_o,
    output logic         err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_PUSH
    } state_e;

    state_e            state_q, state_d;
    logic [5:0]        offset_q, offset_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0][63:0]  line_q, line_d;
    logic              err_q, err_d;
    logic              start_ready_q, start_ready_d;
    logic              rready_q, rready_d;
    logic [2:0]        widx;
    logic              last_beat;

    assign widx      = ptr_q + cnt_q;
    assign last_beat = (cnt_q == 3'd7);

    always_comb begin
        state_d       = state_q;
        offset_d      = offset_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        line_d        = line_q;
        err_d         = 1'b0;
        start_ready_d = start_ready_q;
        rready_d      = rready_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_valid_i) begin
                    offset_d      = start_offset_i;
                    ptr_d         = start_offset_i[5:3];
                    cnt_d         = 3'd0;
                    state_d       = S_COLLECT;
                    start_ready_d = 1'b0;
                    rready_d      = 1'b1;
                end
            end
            S_COLLECT: begin
                if (mem_rvalid_i) begin
                    line_d[widx] = mem_rdata_i;
                    cnt_d        = cnt_q + 3'd1;
                    // The beat count ends the burst; rlast only flags mismatches.
                    err_d        = last_beat ? !mem_rlast_i : mem_rlast_i;
                    if (last_beat) begin
                        state_d  = S_PUSH;
                        rready_d = 1'b0;
                    end
                end
            end
            S_PUSH: begin
                if (!fifo_full_i) begin
                    state_d       = S_IDLE;
                    start_ready_d = 1'b1;
                end
            end
            default: begin
                state_d       = S_IDLE;
                start_ready_d = 1'b1;
                rready_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            offset_q      <= '0;
            ptr_q         <= '0;
            cnt_q         <= '0;
            line_q        <= '0;
            err_q         <= 1'b0;
            start_ready_q <= 1'b1;
            rready_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            offset_q      <= offset_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            line_q        <= line_d;
            err_q         <= err_d;
            start_ready_q <= start_ready_d;
            rready_q      <= rready_d;
        end
    end

    assign start_ready_o = start_ready_q;
    assign mem_rready_o  = rready_q;
    assign err_o         = err_q;
    assign fifo_wren_o   = (state_q == S_PUSH) && !fifo_full_i;
    assign fifo_wdata_o  = {offset_q, line_q};

    a_no_write_when_full: assert property (
        @(posedge clk) disable iff (rst) !(fifo_wren_o && fifo_full_i));
    a_ready_exclusive: assert property (
        @(posedge clk) disable iff (rst) !(start_ready_o && mem_rready_o));

endmodule

// File: tb/tb_cc_deserializer.sv
// Directed bench for cc_deserializer: wrap placement, stalls, rlast
// mismatches, mid-burst reset and back-to-back fills.
module tb_cc_deserializer;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid_i;
    logic [5:0]   start_offset_i;
    logic         start_ready_o;
    logic [63:0]  mem_rdata_i;
    logic         mem_rlast_i;
    logic         mem_rvalid_i;
    logic         mem_rready_o;
    logic         fifo_full_i;
    logic         fifo_wren_o;
    logic [517:0] fifo_wdata_o;
    logic         err_o;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int err_count = 0;
    int cyc = 0;
    int accept_cyc[$];

    cc_deserializer dut (
        .clk            (clk),
        .rst            (rst),
        .start_valid_i  (start_valid_i),
        .start_offset_i (start_offset_i),
        .start_ready_o  (start_ready_o),
        .mem_rdata_i    (mem_rdata_i),
        .mem_rlast_i    (mem_rlast_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rready_o   (mem_rready_o),
        .fifo_full_i    (fifo_full_i),
        .fifo_wren_o    (fifo_wren_o),
        .fifo_wdata_o   (fifo_wdata_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (fifo_wren_o) wr_count++;
        if (err_o) err_count++;
        if (!rst && start_valid_i && start_ready_o) accept_cyc.push_back(cyc);
    end

    function automatic logic [517:0] exp_line(input logic [5:0] off,
                                              input logic [63:0] base);
        logic [517:0] r;
        logic [2:0]   k;
        r = '0;
        r[517:512] = off;
        for (int i = 0; i < 8; i++) begin
            k = off[5:3] + 3'(i);
            r[int'(k)*64 +: 64] = base + 64'(i);
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        start_valid_i  = 1'b0;
        start_offset_i = '0;
        mem_rdata_i    = '0;
        mem_rlast_i    = 1'b0;
        mem_rvalid_i   = 1'b0;
        fifo_full_i    = 1'b0;
    endtask

    task automatic start_req(input logic [5:0] off, input bit hold);
        int n;
        n = 0;
        start_valid_i  = 1'b1;
        start_offset_i = off;
        while (!start_ready_o && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL start_timeout: start_ready_o=%0b required 1", start_ready_o);
        end
        step();
        if (!hold) start_valid_i = 1'b0;
    endtask

    task automatic send_beats(input logic [63:0] base, input logic [7:0] lastm,
                              input int nbeats, input int gap,
                              output logic [7:0] errs);
        int n;
        errs = '0;
        for (int i = 0; i < nbeats; i++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = base + 64'(i);
            mem_rlast_i  = lastm[i];
            n = 0;
            while (!mem_rready_o && n < 100) begin
                step();
                n++;
            end
            if (n >= 100) begin
                checks++;
                errors++;
                $display("FAIL beat_timeout: beat %0d mem_rready_o=0 required 1", i);
            end
            step();
            errs[i]      = err_o;
            mem_rvalid_i = 1'b0;
            mem_rlast_i  = 1'b0;
            if (i < nbeats - 1) repeat (gap) step();
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({start_ready_o, mem_rready_o, fifo_wren_o, err_o} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 1000",
                     {start_ready_o, mem_rready_o, fifo_wren_o, err_o});
        end
        checks++;
        if (fifo_wdata_o !== '0) begin
            errors++;
            $display("FAIL reset_wdata: got %h required 0", fifo_wdata_o);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [7:0] errs;
        int w0, e0;
        w0 = wr_count;
        e0 = err_count;
        start_req(6'h00, 1'b0);
        checks++;
        if ({mem_rready_o, start_ready_o} !== 2'b10) begin
            errors++;
            $display("FAIL basic_accept: rready,sready=%b required 10",
                     {mem_rready_o, start_ready_o});
        end
        send_beats(64'h1000, 8'h80, 8, 0, errs);
        checks++;
        if (fifo_wren_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_wren: got %b required 1", fifo_wren_o);
        end
        checks++;
        if (fifo_wdata_o !== exp_line(6'h00, 64'h1000)) begin
            errors++;
            $display("FAIL basic_data: got %h required %h",
                     fifo_wdata_o, exp_line(6'h00, 64'h1000));
        end
        step();
        checks++;
        if ({fifo_wren_o, start_ready_o} !== 2'b01) begin
            errors++;
            $display("FAIL basic_idle: wren,sready=%b required 01",
                     {fifo_wren_o, start_ready_o});
        end
        checks++;
        if (wr_count - w0 != 1 || err_count != e0 || errs !== 8'h00) begin
            errors++;
            $display("FAIL basic_counts: writes=%0d errpulses=%0d required 1 0",
                     wr_count - w0, err_count - e0);
        end
    endtask

    task automatic test_wrap_offset();
        logic [7:0] errs;
        start_req(6'h10, 1'b0);
        send_beats(64'hB000, 8'h80, 8, 0, errs);
        checks++;
        if (fifo_wdata_o[2*64 +: 64] !== 64'hB000 ||
            fifo_wdata_o[7*64 +: 64] !== 64'hB005 ||
            fifo_wdata_o[0*64 +: 64] !== 64'hB006 ||
            fifo_wdata_o[1*64 +: 64] !== 64'hB007) begin
            errors++;
            $display("FAIL wrap_words: w2=%h w7=%h w0=%h w1=%h required B000 B005 B006 B007",
                     fifo_wdata_o[2*64 +: 64], fifo_wdata_o[7*64 +: 64],
                     fifo_wdata_o[0*64 +: 64], fifo_wdata_o[1*64 +: 64]);
        end
        checks++;
        if (fifo_wdata_o[517:512] !== 6'h10) begin
            errors++;
            $display("FAIL wrap_offset: got %h required 10", fifo_wdata_o[517:512]);
        end
        step();
    endtask

    task automatic test_stall_full();
        logic [7:0]   errs;
        logic [517:0] snap;
        int w0;
        w0 = wr_count;
        fifo_full_i = 1'b1;
        start_req(6'h38, 1'b0);
        send_beats(64'hC000, 8'h80, 8, 1, errs);
        snap = fifo_wdata_o;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (fifo_wren_o !== 1'b0 || start_ready_o !== 1'b0 ||
                fifo_wdata_o !== snap) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d wren=%b sready=%b data changed=%b",
                         c, fifo_wren_o, start_ready_o, fifo_wdata_o !== snap);
            end
            if (c < 2) step();
        end
        step();
        fifo_full_i = 1'b0;
        #1;
        checks++;
        if (fifo_wren_o !== 1'b1 || fifo_wdata_o !== exp_line(6'h38, 64'hC000)) begin
            errors++;
            $display("FAIL stall_release: wren=%b data=%h required 1 %h",
                     fifo_wren_o, fifo_wdata_o, exp_line(6'h38, 64'hC000));
        end
        checks++;
        if (fifo_wdata_o[7*64 +: 64] !== 64'hC000 ||
            fifo_wdata_o[0*64 +: 64] !== 64'hC001) begin
            errors++;
            $display("FAIL stall_words: w7=%h w0=%h required C000 C001",
                     fifo_wdata_o[7*64 +: 64], fifo_wdata_o[0*64 +: 64]);
        end
        step();
        checks++;
        if (wr_count - w0 != 1) begin
            errors++;
            $display("FAIL stall_writes: got %0d required 1", wr_count - w0);
        end
    endtask

    task automatic test_rlast_errors();
        logic [7:0] errs;
        int w0, e0;
        w0 = wr_count;
        e0 = err_count;
        start_req(6'h00, 1'b0);
        send_beats(64'h2000, 8'h88, 8, 0, errs);
        checks++;
        if (errs !== 8'h08) begin
            errors++;
            $display("FAIL rlast_early_pulse: got %b required 00001000", errs);
        end
        checks++;
        if (fifo_wren_o !== 1'b1 || fifo_wdata_o !== exp_line(6'h00, 64'h2000)) begin
            errors++;
            $display("FAIL rlast_early_data: wren=%b data=%h", fifo_wren_o, fifo_wdata_o);
        end
        step();
        checks++;
        if (err_count - e0 != 1 || wr_count - w0 != 1) begin
            errors++;
            $display("FAIL rlast_early_counts: pulses=%0d writes=%0d required 1 1",
                     err_count - e0, wr_count - w0);
        end
        e0 = err_count;
        start_req(6'h18, 1'b0);
        send_beats(64'h3000, 8'h00, 8, 0, errs);
        checks++;
        if (errs !== 8'h80 || fifo_wren_o !== 1'b1 ||
            fifo_wdata_o !== exp_line(6'h18, 64'h3000)) begin
            errors++;
            $display("FAIL rlast_missing: errs=%b wren=%b required 10000000 1",
                     errs, fifo_wren_o);
        end
        step();
        checks++;
        if (err_count - e0 != 1) begin
            errors++;
            $display("FAIL rlast_missing_count: got %0d required 1", err_count - e0);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] errs;
        int w0;
        w0 = wr_count;
        start_req(6'h00, 1'b0);
        send_beats(64'hD000, 8'h00, 5, 0, errs);
        rst = 1'b1;
        step();
        checks++;
        if ({start_ready_o, mem_rready_o, fifo_wren_o, err_o} !== 4'b1000 ||
            fifo_wdata_o !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: ctrl=%b data=%h required 1000 0",
                     {start_ready_o, mem_rready_o, fifo_wren_o, err_o}, fifo_wdata_o);
        end
        rst = 1'b0;
        repeat (3) step();
        checks++;
        if (wr_count != w0) begin
            errors++;
            $display("FAIL midrst_nowrite: writes=%0d required 0", wr_count - w0);
        end
        start_req(6'h08, 1'b0);
        send_beats(64'hE000, 8'h80, 8, 0, errs);
        checks++;
        if (fifo_wren_o !== 1'b1 || fifo_wdata_o !== exp_line(6'h08, 64'hE000) ||
            fifo_wdata_o[1*64 +: 64] !== 64'hE000 ||
            fifo_wdata_o[0*64 +: 64] !== 64'hE007) begin
            errors++;
            $display("FAIL midrst_next: wren=%b data=%h required %h",
                     fifo_wren_o, fifo_wdata_o, exp_line(6'h08, 64'hE000));
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] errs;
        int w0;
        w0 = wr_count;
        accept_cyc.delete();
        for (int b = 0; b < 3; b++) begin
            start_req(6'h20, 1'b1);
            checks++;
            if (start_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL b2b_sready: burst %0d got %b required 0", b, start_ready_o);
            end
            send_beats(64'hF000 + 64'(b * 16), 8'h80, 8, 0, errs);
        end
        start_valid_i = 1'b0;
        step();
        checks++;
        if (wr_count - w0 != 3 || accept_cyc.size() != 3) begin
            errors++;
            $display("FAIL b2b_counts: writes=%0d accepts=%0d required 3 3",
                     wr_count - w0, accept_cyc.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (accept_cyc[i] - accept_cyc[i-1] != 10) begin
                    errors++;
                    $display("FAIL b2b_spacing: gap %0d cycles required 10",
                             accept_cyc[i] - accept_cyc[i-1]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_basic();
        test_wrap_offset();
        test_stall_full();
        test_rlast_errors();
        test_reset_mid_burst();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
